// File: rtl/register_dump_controller.sv
// rtl/register_dump_controller.sv - walks debug read port addresses and streams each word as 4 bytes MSB first
module register_dump_controller #(
  parameter int FIRST_REG    = 0,
  parameter int LAST_REG     = 31,
  parameter int READ_LATENCY = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic [4:0]  dbg_addr,
  input  logic [31:0] dbg_data,
  output logic [7:0]  byte_out,
  output logic        byte_valid,
  input  logic        byte_ready,
  output logic        busy,
  output logic        done
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ISSUE = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_SEND  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [4:0] FIRST_ADDR = 5'(FIRST_REG);
  localparam logic [4:0] LAST_ADDR  = 5'(LAST_REG);
  localparam logic [2:0] LAT        = 3'(READ_LATENCY);

  logic [2:0]  r_state;
  logic [4:0]  r_addr;
  logic [31:0] r_shift;
  logic        r_valid;
  logic        r_done;
  logic [1:0]  r_byte_cnt;
  logic [2:0]  r_wait;
  logic        w_xfer;

  assign w_xfer     = r_valid & byte_ready;
  assign dbg_addr   = r_addr;
  assign byte_out   = r_shift[31:24];
  assign byte_valid = r_valid;
  assign busy       = (r_state != S_IDLE);
  assign done       = r_done;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_addr     <= FIRST_ADDR;
      r_shift    <= 32'h0;
      r_valid    <= 1'b0;
      r_done     <= 1'b0;
      r_byte_cnt <= 2'd0;
      r_wait     <= 3'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_addr  <= FIRST_ADDR;
            r_state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_wait  <= LAT;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          // Address has been stable for READ_LATENCY cycles once the count hits 1 here
          if (r_wait == 3'd1) begin
            r_shift    <= dbg_data;
            r_byte_cnt <= 2'd0;
            r_valid    <= 1'b1;
            r_wait     <= 3'd0;
            r_state    <= S_SEND;
          end else begin
            r_wait <= r_wait - 3'd1;
          end
        end
        S_SEND: begin
          if (w_xfer) begin
            r_shift    <= {r_shift[23:0], 8'h00};
            r_byte_cnt <= r_byte_cnt + 2'd1;
            if (r_byte_cnt == 2'd3) begin
              r_valid <= 1'b0;
              if (r_addr == LAST_ADDR) begin
                r_done  <= 1'b1;
                r_state <= S_DONE;
              end else begin
                r_addr  <= r_addr + 5'd1;
                r_state <= S_ISSUE;
              end
            end
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_register_dump_controller.sv
// tb/tb_register_dump_controller.sv - directed bench for register_dump_controller
module tb_register_dump_controller;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start_a = 1'b0, start_b = 1'b0;
  logic        ready = 1'b1;
  logic [4:0]  addr_a, addr_b;
  logic [31:0] data_a, data_b, pb1, pb2;
  logic [7:0]  byte_a, byte_b;
  logic        valid_a, valid_b, busy_a, busy_b, done_a, done_b;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  logic [31:0] regs [32];

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  register_dump_controller dut_a (
    .clock(clock), .reset(reset), .start(start_a), .dbg_addr(addr_a), .dbg_data(data_a),
    .byte_out(byte_a), .byte_valid(valid_a), .byte_ready(ready), .busy(busy_a), .done(done_a)
  );

  register_dump_controller #(.FIRST_REG(28), .LAST_REG(29), .READ_LATENCY(3)) dut_b (
    .clock(clock), .reset(reset), .start(start_b), .dbg_addr(addr_b), .dbg_data(data_b),
    .byte_out(byte_b), .byte_valid(valid_b), .byte_ready(ready), .busy(busy_b), .done(done_b)
  );

  // Register file debug ports: 1-cycle latency for A, 3-cycle for B
  always @(posedge clock) begin
    data_a <= regs[addr_a];
    pb1    <= regs[addr_b];
    pb2    <= pb1;
    data_b <= pb2;
  end

  logic [7:0] qa[$];
  logic [7:0] qb[$];
  int done_cnt_a = 0, done_cnt_b = 0;
  int done_cyc_a = 0, last_cyc_a = 0, first_issue_a = -1;
  logic prev_valid_a = 0, prev_ready_a = 0, prev_busy_a = 0;
  logic [7:0] prev_byte_a = 0;
  logic prev_busy_b = 0, prev_valid_b = 0;
  logic [4:0] prev_addr_b = 0, max_addr_b = 0;
  int issue_cyc_b = 0;
  int gaps_b[$];

  always @(negedge clock) begin
    if (!reset) begin
      if (valid_a && ready) begin
        qa.push_back(byte_a);
        last_cyc_a = cyc;
      end
      if (done_a) begin
        done_cnt_a++;
        done_cyc_a = cyc;
      end
      if (busy_a && !prev_busy_a && first_issue_a < 0) first_issue_a = cyc;
      if (prev_valid_a && !prev_ready_a) begin
        total++;
        if (valid_a !== 1'b1 || byte_a !== prev_byte_a) begin
          bad++;
          $display("FAIL stall_hold: valid=%0b byte=%02h required valid=1 byte=%02h", valid_a, byte_a, prev_byte_a);
        end
      end
      if (valid_b && ready) qb.push_back(byte_b);
      if (done_b) done_cnt_b++;
      if (busy_b && (!prev_busy_b || addr_b != prev_addr_b)) issue_cyc_b = cyc;
      if (valid_b && !prev_valid_b) gaps_b.push_back(cyc - issue_cyc_b);
      if (busy_b && addr_b > max_addr_b) max_addr_b = addr_b;
    end
    prev_valid_a = valid_a; prev_ready_a = ready; prev_byte_a = byte_a; prev_busy_a = busy_a;
    prev_busy_b = busy_b; prev_valid_b = valid_b; prev_addr_b = addr_b;
  end

  function automatic logic [7:0] exp_byte(input int i);
    logic [31:0] w;
    w = regs[i / 4];
    return w[31 - 8 * (i % 4) -: 8];
  endfunction

  task automatic run_a(input bit rand_ready, input bit extra_starts, output bit timed_out);
    int n = 0;
    bit s10 = 0;
    timed_out = 0;
    start_a = 1; @(posedge clock); #1; start_a = 0;
    while (!done_a) begin
      if (n > 3000) begin timed_out = 1; break; end
      ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      start_a = extra_starts && qa.size() == 10 && !s10;
      if (start_a) s10 = 1;
      @(posedge clock); #1; n++;
    end
    if (extra_starts) start_a = 1;
    ready = 1;
    @(posedge clock); #1; start_a = 0;
  endtask

  task automatic clear_a();
    qa.delete(); done_cnt_a = 0; first_issue_a = -1;
  endtask

  task automatic check_full_a(input string tag);
    int errs = 0;
    total++;
    if (qa.size() !== 128) begin
      bad++; $display("FAIL %s_count: got %0d bytes required 128", tag, qa.size());
    end
    total++;
    for (int i = 0; i < qa.size() && i < 128; i++) if (qa[i] !== exp_byte(i)) errs++;
    if (errs != 0) begin
      bad++; $display("FAIL %s_bytes: %0d wrong bytes required 0", tag, errs);
    end
    total++;
    if (done_cnt_a !== 1) begin
      bad++; $display("FAIL %s_done_count: got %0d required 1", tag, done_cnt_a);
    end
    total++;
    if (busy_a !== 1'b0) begin
      bad++; $display("FAIL %s_busy_after: got %0b required 0", tag, busy_a);
    end
  endtask

  task automatic test_reset();
    reset = 1; @(posedge clock); @(posedge clock); #1;
    total++;
    if ({addr_a, byte_a, valid_a, busy_a, done_a} !== 16'h0) begin
      bad++; $display("FAIL reset_a: addr=%0d byte=%02h v=%0b busy=%0b done=%0b required all 0", addr_a, byte_a, valid_a, busy_a, done_a);
    end
    total++;
    if (addr_b !== 5'd28 || valid_b !== 1'b0 || busy_b !== 1'b0) begin
      bad++; $display("FAIL reset_b: addr=%0d v=%0b busy=%0b required 28 0 0", addr_b, valid_b, busy_b);
    end
    reset = 0; @(posedge clock); #1;
  endtask

  task automatic test_full_dump();
    bit to;
    logic [7:0] w28 [4] = '{8'h10, 8'h00, 8'h80, 8'h00};
    logic [7:0] w29 [4] = '{8'h7f, 8'hff, 8'hef, 8'hfc};
    clear_a();
    run_a(0, 0, to);
    total++;
    if (to) begin bad++; $display("FAIL full_timeout: done=0 required 1"); end
    check_full_a("full");
    total++;
    if (qa.size() == 128 && (qa[0] | qa[1] | qa[2] | qa[3]) !== 8'h00) begin
      bad++; $display("FAIL full_reg0: got %02h%02h%02h%02h required 00000000", qa[0], qa[1], qa[2], qa[3]);
    end
    for (int k = 0; k < 4; k++) begin
      total++;
      if (qa.size() != 128 || qa[112 + k] !== w28[k] || qa[116 + k] !== w29[k]) begin
        bad++; $display("FAIL full_reg28_29_byte%0d: size=%0d required %02h %02h", k, qa.size(), w28[k], w29[k]);
      end
    end
    total++;
    if (done_cyc_a !== last_cyc_a + 1) begin
      bad++; $display("FAIL full_done_timing: done cycle %0d required %0d", done_cyc_a, last_cyc_a + 1);
    end
    total++;
    if (last_cyc_a - first_issue_a !== 191) begin
      bad++; $display("FAIL full_duration: got %0d required 191", last_cyc_a - first_issue_a);
    end
  endtask

  task automatic test_back_pressure();
    bit to;
    clear_a();
    run_a(1, 0, to);
    total++;
    if (to) begin bad++; $display("FAIL bp_timeout: done=0 required 1"); end
    check_full_a("bp");
  endtask

  task automatic test_window();
    int n = 0;
    logic [7:0] exp [8] = '{8'h10, 8'h00, 8'h80, 8'h00, 8'h7f, 8'hff, 8'hef, 8'hfc};
    qb.delete(); gaps_b.delete(); done_cnt_b = 0; max_addr_b = 0;
    start_b = 1; @(posedge clock); #1; start_b = 0;
    while (!done_b && n < 200) begin @(posedge clock); #1; n++; end
    @(posedge clock); #1;
    total++;
    if (qb.size() !== 8) begin bad++; $display("FAIL win_count: got %0d required 8", qb.size()); end
    for (int i = 0; i < 8 && i < qb.size(); i++) begin
      total++;
      if (qb[i] !== exp[i]) begin bad++; $display("FAIL win_byte%0d: got %02h required %02h", i, qb[i], exp[i]); end
    end
    total++;
    if (gaps_b.size() !== 2 || gaps_b[0] !== 4 || gaps_b[1] !== 4) begin
      bad++; $display("FAIL win_gap: n=%0d required two gaps of 4", gaps_b.size());
    end
    total++;
    if (max_addr_b !== 5'd29) begin bad++; $display("FAIL win_max_addr: got %0d required 29", max_addr_b); end
    total++;
    if (done_cnt_b !== 1 || busy_b !== 1'b0) begin
      bad++; $display("FAIL win_done: count=%0d busy=%0b required 1 0", done_cnt_b, busy_b);
    end
  endtask

  task automatic test_start_while_busy();
    bit to;
    clear_a();
    run_a(0, 1, to);
    total++;
    if (to) begin bad++; $display("FAIL swb_timeout: done=0 required 1"); end
    check_full_a("swb");
    repeat (20) @(posedge clock);
    #1;
    total++;
    if (busy_a !== 1'b0 || qa.size() !== 128) begin
      bad++; $display("FAIL swb_no_second: busy=%0b bytes=%0d required 0 128", busy_a, qa.size());
    end
    clear_a();
    run_a(0, 0, to);
    check_full_a("swb_again");
  endtask

  task automatic test_reset_mid_dump();
    bit to;
    int n = 0;
    clear_a();
    start_a = 1; @(posedge clock); #1; start_a = 0;
    while (!(addr_a == 5'd5 && valid_a) && n < 500) begin @(posedge clock); #1; n++; end
    reset = 1; @(posedge clock); #1;
    total++;
    if (valid_a !== 1'b0 || busy_a !== 1'b0 || addr_a !== 5'd0) begin
      bad++; $display("FAIL rst_mid: v=%0b busy=%0b addr=%0d required 0 0 0", valid_a, busy_a, addr_a);
    end
    reset = 0;
    repeat (30) @(posedge clock);
    #1;
    total++;
    if (done_cnt_a !== 0 || busy_a !== 1'b0) begin
      bad++; $display("FAIL rst_mid_no_done: done count=%0d busy=%0b required 0 0", done_cnt_a, busy_a);
    end
    clear_a();
    run_a(0, 0, to);
    check_full_a("rst_restart");
  endtask

  task automatic test_reset_priority();
    reset = 1; start_a = 1; @(posedge clock); #1;
    reset = 0; start_a = 0;
    repeat (3) @(posedge clock);
    #1;
    total++;
    if (busy_a !== 1'b0 || valid_a !== 1'b0) begin
      bad++; $display("FAIL rst_prio: busy=%0b v=%0b required 0 0", busy_a, valid_a);
    end
  endtask

  initial begin
    for (int n = 0; n < 32; n++) regs[n] = n * 32'h01010101;
    regs[28] = 32'h10008000;
    regs[29] = 32'h7fffeffc;
    test_reset();
    test_full_dump();
    test_back_pressure();
    test_window();
    test_start_while_busy();
    test_reset_mid_dump();
    test_reset_priority();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/register_dump_controller.md
Name: register_dump_controller

Overview:
Debug-side reader for the register file's debug read port. On a start pulse it walks register addresses FIRST_REG..LAST_REG and drives each address onto the debug read port. It waits out the port's read latency, captures the 32-bit word, and streams it out as 4 bytes, MSB first, over a valid/ready byte interface that feeds the board's UART/display path. It is the consumer end of read_address_debug/data_out_debug.

Parameters:
FIRST_REG, 0, first register address dumped (0..31)
LAST_REG, 31, last register address dumped (FIRST_REG..31)
READ_LATENCY, 1, clock cycles from dbg_addr change to dbg_data valid (1..4)

Ports:
clock  in  1  single system clock; all logic on posedge
reset  in  1  synchronous, active-high reset
start  in  1  one-cycle request to begin a dump; honoured only in IDLE
dbg_addr  out  5  address driven to the register file debug read port
dbg_data  in  32  data returned by the debug read port
byte_out  out  8  current output byte
byte_valid  out  1  byte_out is valid
byte_ready  in  1  sink accepts byte_out this cycle
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse after the final byte of LAST_REG is accepted

Behaviour:
- Reset values: state=IDLE, dbg_addr=FIRST_REG, byte_out=0, byte_valid=0, busy=0, done=0, shift register=0, byte count=0, wait count=0.
- Reset asserted mid-dump returns to IDLE next edge. No further bytes are emitted and done is not pulsed.
- IDLE: busy=0. start=1 → dbg_addr<=FIRST_REG, go ISSUE.
- ISSUE (1 cycle): dbg_addr holds the current address. Load wait count with READ_LATENCY. Go WAIT.
- WAIT: decrement wait count each cycle. Leave WAIT when the count reaches 0 on the edge that completes READ_LATENCY cycles after ISSUE. On that edge capture dbg_data into a 32-bit shift register, clear byte count, and go SEND.
- dbg_addr must stay stable from ISSUE through capture.
- SEND: byte_valid=1 and byte_out=shift[31:24], both driven from registers.
- SEND transfer: occurs when byte_valid && byte_ready on a clock edge. On each transfer, shift left by 8 (zero-fill) and byte count +1.
- SEND hold: byte_out and byte_valid hold unchanged while byte_ready=0; there is no timeout.
- SEND exit: on the 4th transfer, byte_valid<=0. If dbg_addr==LAST_REG go DONE; otherwise dbg_addr<=dbg_addr+1 and go ISSUE.
- DONE (1 cycle): done=1, busy=1. Next state IDLE, done<=0.
- start outside IDLE is ignored, including start in the DONE cycle. start asserted again after returning to IDLE begins a new dump.
- Address arithmetic is 5-bit. LAST_REG=31 terminates by equality compare, never by wrap, so dbg_addr never wraps to 0.
- Byte order per register is big-endian: [31:24], [23:16], [15:8], [7:0].
- Dump length: (LAST_REG−FIRST_REG+1)×4 bytes. With FIRST_REG=LAST_REG, exactly 4 bytes.
- Timing with byte_ready held high: per register 1 (ISSUE) + READ_LATENCY (WAIT) + 4 (SEND) cycles. A full default dump is 32×6=192 cycles from the first ISSUE to the last accept, plus 1 DONE cycle.
- Register file contents are sampled per register at capture time. Writes during a dump are not coherent across registers; this is accepted.

Test Plan:
- Full dump, default params, byte_ready=1. Model register file: debug port returns data 1 cycle after address; reg[n]=n*0x01010101; reg28=0x10008000; reg29=0x7fffeffc. Pulse start → exactly 128 bytes. Bytes 0..3 = 00 00 00 00. Bytes 112..115 = 10 00 80 00. Bytes 116..119 = 7f ff ef fc. done pulses once, 1 cycle after byte 127. busy drops next cycle.
- Back-pressure: toggle byte_ready pseudo-randomly → identical 128-byte sequence. byte_out is stable whenever byte_valid=1 and byte_ready=0. No byte is duplicated or dropped.
- Window/latency: FIRST_REG=28, LAST_REG=29, READ_LATENCY=3 → bytes 10 00 80 00 7f ff ef fc. Each ISSUE-to-first-valid gap is 4 cycles. dbg_addr goes 28→29 and never 30.
- start while busy: pulse start at byte 10 and again in the DONE cycle → one 128-byte dump only. A later start in IDLE produces a second complete dump.
- Reset mid-dump: assert reset during SEND of register 5. Next cycle byte_valid=0, busy=0, dbg_addr=0, and done is never pulsed. A subsequent start dumps from register 0.
- Reset priority: reset and start asserted in the same cycle → remains IDLE, busy=0.
